// File: rtl/gerenciador_ativos_rr.sv
// rtl/gerenciador_ativos_rr.sv - active-node manager with round-robin slot allocation
module gerenciador_ativos_rr #(
    parameter int NUM_NA          = 8,
    parameter int ADR_WIDTH       = 5,
    parameter int DISTANCIA_WIDTH = 5,
    parameter int CUSTO_WIDTH     = 4,
    parameter int WAIT_ON_FULL    = 0,
    parameter int CNT_WIDTH       = $clog2(NUM_NA + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid_in,
    output logic                          req_ready_out,
    input  logic                          req_op_in,
    input  logic [ADR_WIDTH-1:0]          endereco_in,
    input  logic [ADR_WIDTH-1:0]          anterior_in,
    input  logic [CUSTO_WIDTH-1:0]        menor_vizinho_in,
    input  logic [DISTANCIA_WIDTH-1:0]    distancia_in,
    input  logic [ADR_WIDTH*NUM_NA-1:0]   na_endereco_in,
    input  logic [NUM_NA-1:0]             na_ativo_in,
    output logic                          ga_valid_out,
    output logic                          ga_op_out,
    output logic [ADR_WIDTH-1:0]          ga_endereco_out,
    output logic [ADR_WIDTH-1:0]          ga_anterior_out,
    output logic [CUSTO_WIDTH-1:0]        ga_menor_vizinho_out,
    output logic [DISTANCIA_WIDTH-1:0]    ga_distancia_out,
    output logic [NUM_NA-1:0]             ga_habilitar_out,
    output logic                          ga_hit_out,
    output logic                          ga_cheio_out,
    output logic                          ga_multi_hit_out,
    output logic [CNT_WIDTH-1:0]          ga_ativos_out,
    output logic                          ocupado
);

    localparam int PTR_W = $clog2(NUM_NA);
    localparam logic [PTR_W-1:0] ULTIMO = PTR_W'(NUM_NA - 1);
    localparam logic OP_DESATIVAR = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSCA, ST_ESPERA, ST_RESP} estado_t;

    estado_t                      state_q;
    logic [NUM_NA-1:0]            pendente_q;
    logic [PTR_W-1:0]             rr_ptr_q;
    logic                         op_q;
    logic [ADR_WIDTH-1:0]         endereco_q;
    logic [ADR_WIDTH-1:0]         anterior_q;
    logic [CUSTO_WIDTH-1:0]       menor_vizinho_q;
    logic [DISTANCIA_WIDTH-1:0]   distancia_q;
    logic                         valid_q;
    logic [NUM_NA-1:0]            habilitar_q;
    logic                         hit_q;
    logic                         cheio_q;
    logic                         multi_q;
    logic [CNT_WIDTH-1:0]         ativos_q;

    logic [NUM_NA-1:0]            hit_vec;
    logic [NUM_NA-1:0]            hit_sel;
    logic                         hit_any;
    logic                         multi_hit;
    logic [NUM_NA-1:0]            livre;
    logic [NUM_NA-1:0]            livre_sel;
    logic                         livre_any;
    logic [PTR_W-1:0]             pick_idx;
    logic [PTR_W-1:0]             rr_ptr_d;
    logic                         avaliando;
    logic [NUM_NA-1:0]            aloca_mask;
    logic [NUM_NA-1:0]            pendente_d;
    logic [CNT_WIDTH-1:0]         ativos_d;

    function automatic int wrap_idx(input int a);
        return (a >= NUM_NA) ? a - NUM_NA : a;
    endfunction

    // Address lookup: lowest-index active match wins, a second match flags multi-hit
    always_comb begin
        hit_vec   = '0;
        hit_sel   = '0;
        hit_any   = 1'b0;
        multi_hit = 1'b0;
        for (int i = 0; i < NUM_NA; i++) begin
            hit_vec[i] = na_ativo_in[i] && (na_endereco_in[ADR_WIDTH*i +: ADR_WIDTH] == endereco_q);
        end
        for (int i = 0; i < NUM_NA; i++) begin
            if (hit_vec[i]) begin
                if (hit_any) begin
                    multi_hit = 1'b1;
                end else begin
                    hit_sel[i] = 1'b1;
                    hit_any    = 1'b1;
                end
            end
        end
    end

    // Round-robin free-slot pick starting at rr_ptr; reserved slots are never offered
    always_comb begin
        livre     = ~na_ativo_in & ~pendente_q;
        livre_sel = '0;
        livre_any = 1'b0;
        pick_idx  = '0;
        for (int off = 0; off < NUM_NA; off++) begin
            if (!livre_any && livre[wrap_idx(int'(rr_ptr_q) + off)]) begin
                livre_any = 1'b1;
                livre_sel[wrap_idx(int'(rr_ptr_q) + off)] = 1'b1;
                pick_idx  = PTR_W'(wrap_idx(int'(rr_ptr_q) + off));
            end
        end
        rr_ptr_d = (pick_idx == ULTIMO) ? '0 : pick_idx + PTR_W'(1);
    end

    // Reservation bookkeeping and occupancy count for the next cycle
    always_comb begin
        avaliando  = (state_q == ST_BUSCA) || (state_q == ST_ESPERA);
        aloca_mask = (avaliando && !hit_any && (op_q != OP_DESATIVAR) && livre_any) ? livre_sel : '0;
        pendente_d = (pendente_q | aloca_mask) & ~na_ativo_in;
        ativos_d   = '0;
        for (int i = 0; i < NUM_NA; i++) begin
            ativos_d = ativos_d + CNT_WIDTH'(na_ativo_in[i] | pendente_q[i]);
        end
    end

    // Request FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            pendente_q      <= '0;
            rr_ptr_q        <= '0;
            op_q            <= 1'b0;
            endereco_q      <= '0;
            anterior_q      <= '0;
            menor_vizinho_q <= '0;
            distancia_q     <= '0;
            valid_q         <= 1'b0;
            habilitar_q     <= '0;
            hit_q           <= 1'b0;
            cheio_q         <= 1'b0;
            multi_q         <= 1'b0;
            ativos_q        <= '0;
        end else begin
            valid_q     <= 1'b0;
            habilitar_q <= '0;
            hit_q       <= 1'b0;
            cheio_q     <= 1'b0;
            multi_q     <= 1'b0;
            pendente_q  <= pendente_d;
            ativos_q    <= ativos_d;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_in) begin
                        op_q            <= req_op_in;
                        endereco_q      <= endereco_in;
                        anterior_q      <= anterior_in;
                        menor_vizinho_q <= menor_vizinho_in;
                        distancia_q     <= distancia_in;
                        state_q         <= ST_BUSCA;
                    end
                end
                ST_BUSCA, ST_ESPERA: begin
                    if (hit_any) begin
                        state_q     <= ST_RESP;
                        valid_q     <= 1'b1;
                        habilitar_q <= hit_sel;
                        hit_q       <= 1'b1;
                        multi_q     <= multi_hit;
                    end else if (op_q == OP_DESATIVAR) begin
                        state_q <= ST_RESP;
                        valid_q <= 1'b1;
                    end else if (livre_any) begin
                        state_q     <= ST_RESP;
                        valid_q     <= 1'b1;
                        habilitar_q <= livre_sel;
                        rr_ptr_q    <= rr_ptr_d;
                    end else if (WAIT_ON_FULL != 0) begin
                        state_q <= ST_ESPERA;
                    end else begin
                        state_q <= ST_RESP;
                        valid_q <= 1'b1;
                        cheio_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_out        = (state_q == ST_IDLE);
    assign ocupado              = (state_q != ST_IDLE);
    assign ga_valid_out         = valid_q;
    assign ga_op_out            = op_q;
    assign ga_endereco_out      = endereco_q;
    assign ga_anterior_out      = anterior_q;
    assign ga_menor_vizinho_out = menor_vizinho_q;
    assign ga_distancia_out     = distancia_q;
    assign ga_habilitar_out     = habilitar_q;
    assign ga_hit_out           = hit_q;
    assign ga_cheio_out         = cheio_q;
    assign ga_multi_hit_out     = multi_q;
    assign ga_ativos_out        = ativos_q;

endmodule

// File: tb/tb_gerenciador_ativos_rr.sv
// tb/tb_gerenciador_ativos_rr.sv - directed self-checking bench for gerenciador_ativos_rr
module tb_gerenciador_ativos_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_in, req_valid_w;
    logic        req_op_in;
    logic [4:0]  endereco_in, anterior_in, distancia_in;
    logic [3:0]  menor_vizinho_in;
    logic [39:0] na_endereco_in;
    logic [7:0]  na_ativo_in;
    logic [4:0]  adr [8];

    logic        ready, valid, op, hit, cheio, multi, ocup;
    logic [4:0]  end_o, ant_o, dist_o;
    logic [3:0]  menor_o;
    logic [7:0]  hab;
    logic [3:0]  ativos;

    logic        ready_w, valid_w, op_w, hit_w, cheio_w, multi_w, ocup_w;
    logic [4:0]  end_w, ant_w, dist_w;
    logic [3:0]  menor_w;
    logic [7:0]  hab_w;
    logic [3:0]  ativos_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        na_endereco_in = '0;
        for (int i = 0; i < 8; i++) na_endereco_in[5*i +: 5] = adr[i];
    end

    gerenciador_ativos_rr #(.WAIT_ON_FULL(0)) dut (
        .clk(clk), .rst(rst), .req_valid_in(req_valid_in), .req_ready_out(ready),
        .req_op_in(req_op_in), .endereco_in(endereco_in), .anterior_in(anterior_in),
        .menor_vizinho_in(menor_vizinho_in), .distancia_in(distancia_in),
        .na_endereco_in(na_endereco_in), .na_ativo_in(na_ativo_in),
        .ga_valid_out(valid), .ga_op_out(op), .ga_endereco_out(end_o),
        .ga_anterior_out(ant_o), .ga_menor_vizinho_out(menor_o), .ga_distancia_out(dist_o),
        .ga_habilitar_out(hab), .ga_hit_out(hit), .ga_cheio_out(cheio),
        .ga_multi_hit_out(multi), .ga_ativos_out(ativos), .ocupado(ocup)
    );

    gerenciador_ativos_rr #(.WAIT_ON_FULL(1)) dut_w (
        .clk(clk), .rst(rst), .req_valid_in(req_valid_w), .req_ready_out(ready_w),
        .req_op_in(req_op_in), .endereco_in(endereco_in), .anterior_in(anterior_in),
        .menor_vizinho_in(menor_vizinho_in), .distancia_in(distancia_in),
        .na_endereco_in(na_endereco_in), .na_ativo_in(na_ativo_in),
        .ga_valid_out(valid_w), .ga_op_out(op_w), .ga_endereco_out(end_w),
        .ga_anterior_out(ant_w), .ga_menor_vizinho_out(menor_w), .ga_distancia_out(dist_w),
        .ga_habilitar_out(hab_w), .ga_hit_out(hit_w), .ga_cheio_out(cheio_w),
        .ga_multi_hit_out(multi_w), .ga_ativos_out(ativos_w), .ocupado(ocup_w)
    );

    // Present one request and return 1ns after the accepting edge (cycle T+1)
    task automatic send(input logic w, input logic o, input logic [4:0] a);
        int n = 0;
        req_op_in        = o;
        endereco_in      = a;
        anterior_in      = a ^ 5'h1F;
        menor_vizinho_in = a[3:0];
        distancia_in     = a + 5'd1;
        while (!(w ? ready_w : ready) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) begin
            tests++; fails++;
            $display("FAIL send_timeout: ready stayed 0 for %0d cycles, required 1", n);
        end
        if (w) req_valid_w = 1'b1; else req_valid_in = 1'b1;
        @(posedge clk); #1;
        req_valid_in = 1'b0;
        req_valid_w  = 1'b0;
    endtask

    task automatic test_reset();
        logic saw_valid;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (ocup !== 1'b0) begin fails++; $display("FAIL rst_ocupado: got %b expected 0", ocup); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b expected 1", ready); end
        tests++; if ({valid, hab, hit, cheio, multi} !== 12'h000) begin fails++; $display("FAIL rst_resp: got %h expected 000", {valid, hab, hit, cheio, multi}); end
        tests++; if ({end_o, ant_o, ativos} !== 14'h0) begin fails++; $display("FAIL rst_fields: got %h expected 0000", {end_o, ant_o, ativos}); end
        rst = 1'b0;
        send(1'b0, 1'b0, 5'd1);
        tests++; if (ocup !== 1'b1) begin fails++; $display("FAIL busca_ocupado: got %b expected 1", ocup); end
        rst = 1'b1;
        @(posedge clk); #1;
        tests++; if (ocup !== 1'b0 || valid !== 1'b0) begin fails++; $display("FAIL abort_state: got ocupado=%b valid=%b expected 0 0", ocup, valid); end
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (valid) saw_valid = 1'b1;
        end
        tests++; if (saw_valid !== 1'b0) begin fails++; $display("FAIL abort_no_resp: got valid pulse %b expected 0", saw_valid); end
        tests++; if (ativos !== 4'd0) begin fails++; $display("FAIL abort_pendente: got ativos=%0d expected 0", ativos); end
    endtask

    task automatic test_hit();
        for (int i = 0; i < 8; i++) adr[i] = 5'(16 + i);
        adr[2] = 5'd9;
        na_ativo_in = 8'h04;
        send(1'b0, 1'b0, 5'd9);
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL hit_t1_valid: got %b expected 0", valid); end
        @(posedge clk); #1;
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL hit_valid: got %b expected 1", valid); end
        tests++; if (hab !== 8'h04) begin fails++; $display("FAIL hit_hab: got %h expected 04", hab); end
        tests++; if ({hit, cheio, multi, op} !== 4'b1000) begin fails++; $display("FAIL hit_flags: got %b expected 1000", {hit, cheio, multi, op}); end
        tests++; if ({end_o, ant_o, menor_o, dist_o} !== {5'd9, 5'h16, 4'h9, 5'd10}) begin fails++; $display("FAIL hit_fields: got %h expected %h", {end_o, ant_o, menor_o, dist_o}, {5'd9, 5'h16, 4'h9, 5'd10}); end
        @(posedge clk); #1;
        tests++; if (valid !== 1'b0 || hab !== 8'h00 || hit !== 1'b0) begin fails++; $display("FAIL hit_pulse_end: got valid=%b hab=%h hit=%b expected 0 00 0", valid, hab, hit); end
        tests++; if (end_o !== 5'd9) begin fails++; $display("FAIL hit_hold: got %0d expected 9", end_o); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_hab [3];
        exp_hab[0] = 8'h01; exp_hab[1] = 8'h02; exp_hab[2] = 8'h04;
        na_ativo_in = 8'h00;
        for (int k = 0; k < 3; k++) begin
            send(1'b0, 1'b0, 5'(20 + k));
            @(posedge clk); #1;
            tests++; if (valid !== 1'b1 || hab !== exp_hab[k] || hit !== 1'b0) begin fails++; $display("FAIL b2b_%0d: got valid=%b hab=%h hit=%b expected 1 %h 0", k, valid, hab, hit, exp_hab[k]); end
        end
        @(posedge clk); #1;
        tests++; if (ativos !== 4'd3) begin fails++; $display("FAIL b2b_ativos: got %0d expected 3", ativos); end
        na_ativo_in = 8'h07;
        @(posedge clk); #1;
        na_ativo_in = 8'h00;
        @(posedge clk); #1;
        tests++; if (ativos !== 4'd0) begin fails++; $display("FAIL b2b_clear: got %0d expected 0", ativos); end
    endtask

    task automatic test_wrap();
        na_ativo_in = 8'h38;
        send(1'b0, 1'b0, 5'd25);
        @(posedge clk); #1;
        tests++; if (hab !== 8'h40) begin fails++; $display("FAIL wrap_pre: got %h expected 40", hab); end
        na_ativo_in = 8'h80;
        send(1'b0, 1'b0, 5'd26);
        @(posedge clk); #1;
        tests++; if (hab !== 8'h01) begin fails++; $display("FAIL wrap_slot0: got %h expected 01", hab); end
        send(1'b0, 1'b0, 5'd27);
        @(posedge clk); #1;
        tests++; if (hab !== 8'h02) begin fails++; $display("FAIL wrap_ptr1: got %h expected 02", hab); end
        na_ativo_in = 8'hFF;
        @(posedge clk); #1;
    endtask

    task automatic test_full_no_wait();
        na_ativo_in = 8'hFF;
        send(1'b0, 1'b0, 5'd30);
        @(posedge clk); #1;
        tests++; if (valid !== 1'b1 || cheio !== 1'b1) begin fails++; $display("FAIL full_cheio: got valid=%b cheio=%b expected 1 1", valid, cheio); end
        tests++; if (hab !== 8'h00 || hit !== 1'b0) begin fails++; $display("FAIL full_hab: got hab=%h hit=%b expected 00 0", hab, hit); end
    endtask

    task automatic test_full_wait();
        logic early;
        na_ativo_in = 8'hFF;
        send(1'b1, 1'b0, 5'd30);
        early = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (valid_w) early = 1'b1;
        end
        tests++; if (early !== 1'b0 || ocup_w !== 1'b1) begin fails++; $display("FAIL wait_hold: got early=%b ocupado=%b expected 0 1", early, ocup_w); end
        na_ativo_in = 8'hF7;
        @(posedge clk); #1;
        tests++; if (valid_w !== 1'b1 || hab_w !== 8'h08) begin fails++; $display("FAIL wait_resp: got valid=%b hab=%h expected 1 08", valid_w, hab_w); end
        tests++; if ({cheio_w, hit_w} !== 2'b00) begin fails++; $display("FAIL wait_flags: got %b expected 00", {cheio_w, hit_w}); end
        @(posedge clk); #1;
        tests++; if (valid_w !== 1'b0) begin fails++; $display("FAIL wait_pulse_end: got %b expected 0", valid_w); end
        na_ativo_in = 8'hFF;
        @(posedge clk); #1;
    endtask

    task automatic test_multi_hit();
        na_ativo_in = 8'h42;
        adr[1] = 5'd3;
        adr[6] = 5'd3;
        send(1'b0, 1'b1, 5'd3);
        @(posedge clk); #1;
        tests++; if (valid !== 1'b1 || hab !== 8'h02) begin fails++; $display("FAIL multi_hab: got valid=%b hab=%h expected 1 02", valid, hab); end
        tests++; if ({hit, multi, op, cheio} !== 4'b1110) begin fails++; $display("FAIL multi_flags: got %b expected 1110", {hit, multi, op, cheio}); end
        send(1'b0, 1'b1, 5'd4);
        @(posedge clk); #1;
        tests++; if (valid !== 1'b1 || hab !== 8'h00) begin fails++; $display("FAIL miss_hab: got valid=%b hab=%h expected 1 00", valid, hab); end
        tests++; if ({hit, multi, cheio} !== 3'b000) begin fails++; $display("FAIL miss_flags: got %b expected 000", {hit, multi, cheio}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_valid_in = 1'b0;
        req_valid_w = 1'b0;
        req_op_in = 1'b0;
        endereco_in = '0;
        anterior_in = '0;
        menor_vizinho_in = '0;
        distancia_in = '0;
        na_ativo_in = 8'h00;
        for (int i = 0; i < 8; i++) adr[i] = 5'(16 + i);
        test_reset();
        test_hit();
        test_back_to_back();
        test_wrap();
        test_full_no_wait();
        test_full_wait();
        test_multi_hit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gerenciador_ativos_rr.md
Name: gerenciador_ativos_rr

Overview:
Next-generation active-node (NA) manager for the path-search engine. It takes update/deactivate requests over a valid/ready handshake and looks up the requested address among the NA slots. On an update miss it allocates a free slot using a round-robin scan. It replaces the FIFO-based free finder with a reservation mask, so a slot is never granted twice before the NA reports itself active. It also adds a configurable full policy, multi-hit detection and an occupancy count.

Parameters:
NUM_NA, 8, number of NA slots (2..64)
ADR_WIDTH, 5, node address width
DISTANCIA_WIDTH, 5, distance field width
CUSTO_WIDTH, 4, cost field width
WAIT_ON_FULL, 0, 1 = update miss with no free slot waits; 0 = respond immediately with cheio
CNT_WIDTH, $clog2(NUM_NA+1), occupancy count width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid_in  in  1  request valid
req_ready_out  out  1  high only in ST_IDLE
req_op_in  in  1  0 = ATUALIZAR, 1 = DESATIVAR
endereco_in  in  ADR_WIDTH  node address
anterior_in  in  ADR_WIDTH  predecessor address
menor_vizinho_in  in  CUSTO_WIDTH  cost
distancia_in  in  DISTANCIA_WIDTH  distance
na_endereco_in  in  ADR_WIDTH*NUM_NA  flattened slot addresses; slot i at [ADR_WIDTH*i +: ADR_WIDTH]
na_ativo_in  in  NUM_NA  slot active flags
ga_valid_out  out  1  one-cycle response strobe
ga_op_out  out  1  echoed op
ga_endereco_out, ga_anterior_out, ga_menor_vizinho_out, ga_distancia_out  out  field widths  request fields captured at accept
ga_habilitar_out  out  NUM_NA  one-hot selected slot; zero when no slot is selected
ga_hit_out  out  1  address found active
ga_cheio_out  out  1  update refused, no free slot
ga_multi_hit_out  out  1  more than one active slot matched
ga_ativos_out  out  CNT_WIDTH  popcount(na_ativo_in | pendente), registered
ocupado  out  1  state != ST_IDLE

Behaviour:
- Reset (sync, rst=1): state=ST_IDLE, pendente=0, rr_ptr=0. All ga_* outputs are 0, ga_ativos_out=0. Reset overrides any in-flight request; no response is issued for it.
- Accept when req_valid_in && req_ready_out (cycle T). The request fields and op are registered into the ga_* field outputs, which hold until the next accept.
- FSM states: ST_IDLE, ST_BUSCA, ST_ESPERA, ST_RESP.
- ST_IDLE -> ST_BUSCA on accept.
- ST_BUSCA (T+1):
  - hit[i] = na_ativo_in[i] && slot address == ga_endereco_out.
  - Any hit -> ST_RESP with habilitar = lowest-index hit, ga_hit_out=1, ga_multi_hit_out = (popcount(hit) > 1).
  - ATUALIZAR with no hit:
    - livre = ~na_ativo_in & ~pendente.
    - If livre != 0: pick the first free index scanning rr_ptr, rr_ptr+1, ... modulo NUM_NA, then go to ST_RESP.
    - Else WAIT_ON_FULL=1 -> ST_ESPERA.
    - Else -> ST_RESP with habilitar=0, ga_cheio_out=1.
  - DESATIVAR with no hit -> ST_RESP with habilitar=0, hit=0, cheio=0 (miss).
- ST_ESPERA: re-evaluates hit and then livre every cycle with the ST_BUSCA rules, hit taking priority. Leaves as soon as either resolves. No timeout.
- ST_RESP: ga_valid_out=1 and the ga_habilitar_out/hit/cheio/multi_hit values are driven for exactly this cycle; all are 0 in every other cycle. Next state is ST_IDLE.
- Allocation is the transition into ST_RESP with a free pick:
  - set pendente[k];
  - rr_ptr <= (k == NUM_NA-1) ? 0 : k+1.
- pendente[i] clears in any cycle where na_ativo_in[i]=1. If set and clear fall on the same slot in the same cycle, clear wins only if na_ativo_in[k] is already 1, which cannot happen because k was chosen as free.
- Latency: accept-to-response is 2 cycles (T+2) unless waiting. Next accept is possible at T+3, so throughput is 1 request per 3 cycles.
- Request inputs are ignored while req_ready_out=0.
- ga_ativos_out updates every cycle, 1-cycle latency. Maximum value is NUM_NA, which always fits in CNT_WIDTH.

Test Plan:
- Reset with rst=1 mid-BUSCA -> next cycle ocupado=0, pendente=0, ga_valid_out never pulses for the aborted request.
- na_ativo_in=8'h04, slot2 addr=5'd9, ATUALIZAR addr 9 -> at T+2 ga_valid_out=1, ga_habilitar_out=8'h04, ga_hit_out=1; rr_ptr unchanged.
- na_ativo_in=8'h00, rr_ptr=0; three back-to-back ATUALIZAR misses with na_ativo_in held 0 -> habilitar 8'h01, 8'h02, 8'h04 (pending prevents reuse); ga_ativos_out reaches 3.
- rr_ptr=7 with slot7 busy and slot0 free -> habilitar=8'h01 and rr_ptr wraps to 1.
- All slots active, WAIT_ON_FULL=0, ATUALIZAR miss -> T+2 ga_cheio_out=1, habilitar=0. Same case with WAIT_ON_FULL=1: drop na_ativo_in[3] at T+5 -> response at T+6 with habilitar=8'h08.
- Slots 1 and 6 active, both addr=5'd3, DESATIVAR addr 3 -> habilitar=8'h02, ga_multi_hit_out=1. DESATIVAR addr 4 -> valid with hit=0, habilitar=0.
